// File: rtl/score_scan.sv
// -----------------------------------------------------------------------------
// score_scan
//   Four-digit packed-BCD score counter plus a time-multiplexed scan controller
//   for a four-position seven-segment display. The selected digit is presented
//   on a shared 4-bit bus for an external hex-to-segment decoder, and the
//   matching active-low anode is driven low (or all anodes stay high when that
//   position is a blanked leading zero).
//
// Parameters
//   REFRESH_DIV : cycles each digit position stays selected (>= 2)
//   BLANK_LEAD  : 1 blanks leading-zero positions 1..3, 0 shows all four
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   inc       in   score increment request (one step per high cycle)
//   clr       in   synchronous score clear, has priority over inc
//   score_bcd out  registered score, [15:12] thousands .. [3:0] ones
//   digit     out  BCD digit of the currently selected position
//   an        out  active-low anode selects, bit k = position k (0 = ones)
//   max       out  high while the score is 9999
// -----------------------------------------------------------------------------
module score_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] score_bcd,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        max
);

  localparam int              PW   = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   TERM = PW'(REFRESH_DIV - 1);

  logic [15:0]   r_score;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_sel;

  logic [15:0]   w_score_inc;
  logic [4:0]    w_carry;
  logic          w_at_max;
  logic [3:0]    w_zero_from;   // bit k: nibbles k..3 are all zero
  logic          w_blank;

  // ---------------------------------------------------------------------------
  // Ripple-carry BCD increment. Each nibble rolls 9->0 only when every lower
  // nibble is 9; the all-nines case is never committed because of saturation.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_score_inc = r_score;
    w_carry     = '0;
    w_carry[0]  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (w_carry[k]) begin
        if (r_score[4*k +: 4] == 4'd9) begin
          w_score_inc[4*k +: 4] = 4'd0;
          w_carry[k+1]          = 1'b1;
        end else begin
          w_score_inc[4*k +: 4] = r_score[4*k +: 4] + 4'd1;
        end
      end
    end
  end

  assign w_at_max = (r_score == 16'h9999);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= 16'h0000;
    end else if (clr) begin
      r_score <= 16'h0000;
    end else if (inc && !w_at_max) begin
      r_score <= w_score_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and scan index. Independent of inc/clr so the scan rate never
  // jitters with game activity.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_sel   <= 2'd0;
    end else if (r_presc == TERM) begin
      r_presc <= '0;
      r_sel   <= r_sel + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking. Position 0 is never blanked so a zero score still
  // shows a single "0". The digit bus keeps carrying the real (zero) nibble in
  // blanked slots so the decoder always sees a legal BCD code.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_zero_from[3] = (r_score[15:12] == 4'd0);
    w_zero_from[2] = w_zero_from[3] && (r_score[11:8] == 4'd0);
    w_zero_from[1] = w_zero_from[2] && (r_score[7:4]  == 4'd0);
    w_zero_from[0] = 1'b0;
  end

  assign w_blank = BLANK_LEAD && w_zero_from[r_sel];

  always_comb begin
    digit = 4'd0;
    case (r_sel)
      2'd0: digit = r_score[3:0];
      2'd1: digit = r_score[7:4];
      2'd2: digit = r_score[11:8];
      2'd3: digit = r_score[15:12];
      default: digit = 4'd0;
    endcase
  end

  // At most one anode bit is ever low: a one-hot shift of a single index.
  assign an        = w_blank ? 4'b1111 : ~(4'b0001 << r_sel);
  assign score_bcd = r_score;
  assign max       = w_at_max;

endmodule

// File: tb/tb_score_scan.sv
module tb_score_scan;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic        inc;
  logic        clr;
  logic [15:0] score_a, score_b;
  logic [3:0]  digit_a, digit_b;
  logic [3:0]  an_a, an_b;
  logic        max_a, max_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int score_m = 0;
  int cyc     = 0;   // rising edges since reset release

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  score_scan #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b1)) dut_a (
    .clk(clk), .rst(rst), .inc(inc), .clr(clr),
    .score_bcd(score_a), .digit(digit_a), .an(an_a), .max(max_a)
  );

  score_scan #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b0)) dut_b (
    .clk(clk), .rst(rst), .inc(inc), .clr(clr),
    .score_bcd(score_b), .digit(digit_b), .an(an_b), .max(max_b)
  );

  // ---------------------------------------------------------------------------
  // reference model (decimal arithmetic on an integer score)
  // ---------------------------------------------------------------------------
  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  function automatic int sel_m();
    return (cyc / DIV) % 4;
  endfunction

  function automatic logic [3:0] digit_m(input int s);
    return 4'((score_m / pow10(s)) % 10);
  endfunction

  function automatic logic [3:0] an_m(input int s, input bit blank);
    logic [3:0] a;
    if (blank && s > 0 && score_m < pow10(s)) return 4'b1111;
    a = 4'b1111;
    a[s] = 1'b0;
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int s;
    s = sel_m();
    chk("score_a", 32'(score_a), 32'(to_bcd(score_m)));
    chk("max_a",   32'(max_a),   32'(score_m == 9999));
    chk("digit_a", 32'(digit_a), 32'(digit_m(s)));
    chk("an_a",    32'(an_a),    32'(an_m(s, 1'b1)));
    chk("score_b", 32'(score_b), 32'(to_bcd(score_m)));
    chk("digit_b", 32'(digit_b), 32'(digit_m(s)));
    chk("an_b",    32'(an_b),    32'(an_m(s, 1'b0)));
  endtask

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic i_inc, input logic i_clr);
    inc = i_inc;
    clr = i_clr;
    @(posedge clk);
    if (!rst) begin
      if (i_clr) score_m = 0;
      else if (i_inc && score_m < 9999) score_m = score_m + 1;
      cyc++;
    end
    #1;
    check_all();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic align_sel(input int k);
    for (int g = 0; g < 4 * DIV && sel_m() != k; g++) step(1'b0, 1'b0);
    chk("align_sel", 32'(sel_m()), 32'(k));
  endtask

  task automatic align_frame();
    for (int g = 0; g < 4 * DIV && (cyc % (4 * DIV)) != 0; g++) step(1'b0, 1'b0);
    chk("align_frame", 32'(cyc % (4 * DIV)), 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    score_m = 0;
    cyc = 0;
  endtask

  logic [3:0] tbl_an [4];
  logic [3:0] tbl_dg [4];

  // ---------------------------------------------------------------------------
  // directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    inc = 1'b0;
    clr = 1'b0;
    #1;
    chk("rst_score", 32'(score_a), 32'h0);
    chk("rst_an",    32'(an_a),    32'b1110);
    chk("rst_digit", 32'(digit_a), 32'h0);
    chk("rst_max",   32'(max_a),   32'h0);
    release_rst();

    // first slot after release is a full DIV cycles at position 0
    for (int i = 0; i < DIV - 1; i++) begin
      step(1'b0, 1'b0);
      chk("slot0_hold", 32'(an_a), 32'b1110);
    end

    // 12 increments -> 0012, then scan sequence over two frames
    pulses(12);
    chk("s12_score", 32'(score_a), 32'h0012);
    tbl_an = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    tbl_dg = '{4'd2, 4'd1, 4'd0, 4'd0};
    align_frame();
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < DIV; c++) begin
          chk("s12_an",    32'(an_a),    32'(tbl_an[s]));
          chk("s12_digit", 32'(digit_a), 32'(tbl_dg[s]));
          step(1'b0, 1'b0);
        end

    // 0099 -> 0100: position 2 unblanks, position 3 stays blank
    step(1'b0, 1'b1);
    pulses(99);
    chk("s99_score", 32'(score_a), 32'h0099);
    align_sel(2);
    chk("s99_an2", 32'(an_a), 32'b1111);
    step(1'b1, 1'b0);
    chk("s100_score", 32'(score_a), 32'h0100);
    align_sel(2);
    chk("s100_an2",    32'(an_a),    32'b1011);
    chk("s100_digit2", 32'(digit_a), 32'd1);
    align_sel(3);
    chk("s100_an3",    32'(an_a),    32'b1111);
    chk("s100_digit3", 32'(digit_a), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));

    // clr beats inc at 0057
    step(1'b0, 1'b1);
    pulses(57);
    chk("s57_score", 32'(score_a), 32'h0057);
    step(1'b1, 1'b1);
    chk("clr_score", 32'(score_a), 32'h0000);
    chk("clr_max",   32'(max_a),   32'h0);

    // no blanking variant at 0007
    pulses(7);
    tbl_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tbl_dg = '{4'd7, 4'd0, 4'd0, 4'd0};
    align_frame();
    for (int s = 0; s < 4; s++) begin
      chk("nb_an",    32'(an_b),    32'(tbl_an[s]));
      chk("nb_digit", 32'(digit_b), 32'(tbl_dg[s]));
      for (int c = 0; c < DIV; c++) step(1'b0, 1'b0);
    end

    // asynchronous reset mid-frame at 0345, position 2
    step(1'b0, 1'b1);
    pulses(345);
    align_sel(2);
    step(1'b0, 1'b0);
    chk("pre_rst_an",    32'(an_a),    32'b1011);
    chk("pre_rst_digit", 32'(digit_a), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_an",    32'(an_a),    32'b1110);
    chk("arst_digit", 32'(digit_a), 32'd0);
    chk("arst_score", 32'(score_a), 32'h0000);
    chk("arst_max",   32'(max_a),   32'h0);
    @(posedge clk);
    release_rst();
    for (int i = 0; i < DIV - 1; i++) begin
      step(1'b0, 1'b0);
      chk("arst_slot0", 32'(an_a), 32'b1110);
    end
    step(1'b0, 1'b0);
    chk("arst_slot1", 32'(an_a), 32'b1111);

    // saturation at 9999
    step(1'b0, 1'b1);
    pulses(9998);
    chk("s9998_score", 32'(score_a), 32'h9998);
    chk("s9998_max",   32'(max_a),   32'h0);
    step(1'b1, 1'b0);
    chk("sat1_score", 32'(score_a), 32'h9999);
    chk("sat1_max",   32'(max_a),   32'h1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("sat3_score", 32'(score_a), 32'h9999);
    chk("sat3_max",   32'(max_a),   32'h1);
    step(1'b0, 1'b1);
    chk("final_clr", 32'(score_a), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
